tmr_alu_retry_ctrl: RTL and testbench
=====================================

Name: tmr_alu_retry_ctrl

Overview:
Sequencer in front of the triple-modular-redundant ALU (three replica ALUs plus majority voters). It accepts one ALU operation at a time over a valid/ready handshake and fans the operands out to all three replicas. It samples the voter flags, retries the operation when a voter reports no majority, and returns the voted result with corrected/fatal status. It also keeps saturating fault statistics for the processor's fault-monitor logic.

Parameters:
MAX_RETRY, 2, re-executions allowed after invalidOutput before declaring fatal (0..7)
CNT_W, 16, width of saturating statistics counters

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_opcode  in  5  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra)
req_shamt  in  5  shift amount
req_a  in  32  operand A
req_b  in  32  operand B
alu_inA1/alu_inA2/alu_inA3  out  32 each  replica operand A buses
alu_inB1/alu_inB2/alu_inB3  out  32 each  replica operand B buses
alu_opcode  out  5  shared opcode to replicas
alu_shamt  out  5  shared shift amount
v_result  in  32  voted result
v_err_result, v_inv_result  in  1 each  result voter errorDetected / invalidOutput
v_isNotEqual, v_err_ne, v_inv_ne  in  1 each  isNotEqual voter out / errorDetected / invalidOutput
v_isLessThan, v_err_lt, v_inv_lt  in  1 each  isLessThan voter out / errorDetected / invalidOutput
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_result  out  32  voted result
resp_isNotEqual, resp_isLessThan  out  1 each  voted flags (meaningful for sub only, else 0)
resp_corrected  out  1  single-replica disagreement masked by vote
resp_fatal  out  1  no majority after MAX_RETRY retries
resp_illegal  out  1  opcode > 5, ALU not exercised
resp_retries  out  3  retries consumed
corrected_count  out  CNT_W  saturating count of corrected responses
fatal_count  out  CNT_W  saturating count of fatal responses

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; all resp_* = 0; all alu_* outputs = 0; retry counter 0; both statistics counters 0. A reset mid-operation abandons the operation and drops any pending response.
- States: IDLE, EXEC, RETRY, RESP.
- IDLE: req_ready=1. On req_valid&req_ready:
  - opcode > 5: go to RESP with resp_illegal=1 and all other resp_* = 0. Counters unchanged.
  - otherwise: register opcode, shamt, a, b; drive identical copies to all three replicas; retry counter = 0; go to EXEC.
- alu_* outputs hold their registered values in EXEC, RETRY and RESP. They change only on acceptance.
- EXEC (one cycle): sample voter outputs at the end of the cycle. Checked voters are result only, or result, ne and lt when opcode = 1. inv = OR of checked invalidOutput flags; err = OR of checked errorDetected flags.
  - inv=0: latch v_result and flags (flags forced 0 unless sub). resp_corrected=err. Go to RESP. Increment corrected_count if err.
  - inv=1 and retries < MAX_RETRY: retries+1, go to RETRY.
  - inv=1 and retries = MAX_RETRY: resp_fatal=1, resp_result=v_result as sampled, increment fatal_count, go to RESP.
- RETRY (one settle cycle): go to EXEC.
- RESP: resp_valid=1 and req_ready=0. All resp_* stay stable until resp_valid&resp_ready. On acceptance: resp_valid=0 next cycle, clear resp_* flags, go to IDLE. No request is accepted in the same cycle as response acceptance.
- Latency: request accepted at edge N, resp_valid at N+2 with no retries. Each retry adds 2 cycles.
- Counters saturate at all-ones with no wrap.

Decomposition:
- Shared package tmr_alu_pkg: opcode constants (ADD=0..SRA=5), OP_MAX=5, state encodings.
- One natural sub-module: sat_counter (CNT_W-wide, inc, synchronous reset), instantiated twice.

Test Plan:
- Clean add: a=5, b=7, op 0, voters clean, v_result=12 -> resp_valid 2 cycles after accept; result 12, corrected=0, fatal=0, retries=0.
- Corrected sub: op 1, v_err_ne=1, v_inv_*=0, v_isNotEqual=1 -> resp_corrected=1, resp_isNotEqual=1, corrected_count=1.
- Transient fault: v_inv_result=1 on first EXEC, clean on second -> resp_valid at accept+4, retries=1, fatal=0.
- Persistent fault: v_inv_result=1 always, MAX_RETRY=2 -> resp at accept+6, fatal=1, retries=2, fatal_count=1.
- Illegal opcode 9 -> resp_illegal=1 at accept+1 cycle. alu_* unchanged, counters unchanged.
- Backpressure/reset: hold resp_ready=0 for 5 cycles -> response stable and req_ready=0; then assert reset in EXEC -> next cycle IDLE, resp_valid=0, counters 0.

Source files
------------

// File: rtl/tmr_alu_pkg.sv
`default_nettype none
// tmr_alu_pkg -- opcodes, FSM states and response record shared by the TMR ALU sequencer.
// Rev 1.0
package tmr_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_SLL = 5'd4,
    OP_SRA = 5'd5
  } opcode_e;

  localparam logic [4:0] OP_MAX = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_RETRY = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        corrected;
    logic        fatal;
    logic        illegal;
    logic [2:0]  retries;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/tmr_alu_retry_ctrl_if.sv
`default_nettype none
// tmr_alu_retry_ctrl_if -- request, replica, voter and response buses of the TMR sequencer.
// Rev 1.0
interface tmr_alu_retry_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_opcode;
  logic [4:0]       req_shamt;
  logic [31:0]      req_a;
  logic [31:0]      req_b;

  logic [31:0]      alu_inA1, alu_inA2, alu_inA3;
  logic [31:0]      alu_inB1, alu_inB2, alu_inB3;
  logic [4:0]       alu_opcode;
  logic [4:0]       alu_shamt;

  logic [31:0]      v_result;
  logic             v_err_result, v_inv_result;
  logic             v_isNotEqual, v_err_ne, v_inv_ne;
  logic             v_isLessThan, v_err_lt, v_inv_lt;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic             resp_isNotEqual, resp_isLessThan;
  logic             resp_corrected, resp_fatal, resp_illegal;
  logic [2:0]       resp_retries;

  logic [CNT_W-1:0] corrected_count;
  logic [CNT_W-1:0] fatal_count;

  // Controller side
  modport slave (
    input  req_valid, req_opcode, req_shamt, req_a, req_b,
    output req_ready,
    output alu_inA1, alu_inA2, alu_inA3, alu_inB1, alu_inB2, alu_inB3, alu_opcode, alu_shamt,
    input  v_result, v_err_result, v_inv_result,
    input  v_isNotEqual, v_err_ne, v_inv_ne, v_isLessThan, v_err_lt, v_inv_lt,
    output resp_valid, resp_result, resp_isNotEqual, resp_isLessThan,
    output resp_corrected, resp_fatal, resp_illegal, resp_retries,
    input  resp_ready,
    output corrected_count, fatal_count
  );

  // Requester / replica-array side
  modport master (
    output req_valid, req_opcode, req_shamt, req_a, req_b,
    input  req_ready,
    input  alu_inA1, alu_inA2, alu_inA3, alu_inB1, alu_inB2, alu_inB3, alu_opcode, alu_shamt,
    output v_result, v_err_result, v_inv_result,
    output v_isNotEqual, v_err_ne, v_inv_ne, v_isLessThan, v_err_lt, v_inv_lt,
    input  resp_valid, resp_result, resp_isNotEqual, resp_isLessThan,
    input  resp_corrected, resp_fatal, resp_illegal, resp_retries,
    output resp_ready,
    input  corrected_count, fatal_count
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// sat_counter -- CNT_W-wide event counter that sticks at all-ones.
// Rev 1.0
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/tmr_alu_retry_ctrl.sv
`default_nettype none
// tmr_alu_retry_ctrl -- issues one op to three ALU replicas, retries on no-majority votes,
// returns the voted result with corrected/fatal status. Rev 1.0
module tmr_alu_retry_ctrl
  import tmr_alu_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  wire logic          clock,
  input  wire logic          reset,
  tmr_alu_retry_ctrl_if.slave bus
);
  state_t      r_state, w_next_state;
  logic [4:0]  r_op, r_shamt;
  logic [31:0] r_a, r_b;
  logic [2:0]  r_retries;
  resp_t       r_resp, w_resp_exec;

  logic w_accept, w_illegal, w_resp_done;
  logic w_is_sub, w_inv, w_err, w_retry_ok;
  logic w_inc_corr, w_inc_fatal;

  assign w_illegal  = (bus.req_opcode > OP_MAX);
  assign w_is_sub   = (r_op == OP_SUB);
  // Comparison voters only carry meaning for subtraction.
  assign w_inv      = bus.v_inv_result | (w_is_sub & (bus.v_inv_ne | bus.v_inv_lt));
  assign w_err      = bus.v_err_result | (w_is_sub & (bus.v_err_ne | bus.v_err_lt));
  assign w_retry_ok = (r_retries < 3'(MAX_RETRY));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_resp_done  = 1'b0;
    w_inc_corr   = 1'b0;
    w_inc_fatal  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = w_illegal ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!w_inv) begin
          w_next_state = ST_RESP;
          w_inc_corr   = w_err;
        end else if (w_retry_ok) begin
          w_next_state = ST_RETRY;
        end else begin
          w_next_state = ST_RESP;
          w_inc_fatal  = 1'b1;
        end
      end
      ST_RETRY: w_next_state = ST_EXEC;
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_resp_done  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Response captured at the end of an EXEC cycle; fatal responses carry no flags.
  always_comb begin
    w_resp_exec         = '0;
    w_resp_exec.result  = bus.v_result;
    w_resp_exec.retries = r_retries;
    if (w_inv) begin
      w_resp_exec.fatal = 1'b1;
    end else begin
      w_resp_exec.corrected = w_err;
      w_resp_exec.ne        = w_is_sub & bus.v_isNotEqual;
      w_resp_exec.lt        = w_is_sub & bus.v_isLessThan;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op      <= '0;
      r_shamt   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_retries <= '0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_resp         <= '0;
            r_resp.illegal <= w_illegal;
            if (!w_illegal) begin
              r_op      <= bus.req_opcode;
              r_shamt   <= bus.req_shamt;
              r_a       <= bus.req_a;
              r_b       <= bus.req_b;
              r_retries <= '0;
            end
          end
        end
        ST_EXEC: begin
          if (!w_inv || !w_retry_ok) begin
            r_resp <= w_resp_exec;
          end else begin
            r_retries <= r_retries + 3'd1;
          end
        end
        ST_RESP: begin
          if (w_resp_done) begin
            r_resp <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = (r_state == ST_IDLE);
  assign bus.resp_valid      = (r_state == ST_RESP);
  assign bus.alu_inA1        = r_a;
  assign bus.alu_inA2        = r_a;
  assign bus.alu_inA3        = r_a;
  assign bus.alu_inB1        = r_b;
  assign bus.alu_inB2        = r_b;
  assign bus.alu_inB3        = r_b;
  assign bus.alu_opcode      = r_op;
  assign bus.alu_shamt       = r_shamt;
  assign bus.resp_result     = r_resp.result;
  assign bus.resp_isNotEqual = r_resp.ne;
  assign bus.resp_isLessThan = r_resp.lt;
  assign bus.resp_corrected  = r_resp.corrected;
  assign bus.resp_fatal      = r_resp.fatal;
  assign bus.resp_illegal    = r_resp.illegal;
  assign bus.resp_retries    = r_resp.retries;

  sat_counter #(.CNT_W(CNT_W)) u_corrected_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_inc   (w_inc_corr),
    .o_count (bus.corrected_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fatal_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_inc   (w_inc_fatal),
    .o_count (bus.fatal_count)
  );
endmodule
`default_nettype wire

// File: tb/tb_tmr_alu_retry_ctrl.sv
`default_nettype none
// tb_tmr_alu_retry_ctrl -- scoreboard bench with a three-replica ALU and voter model.
// Rev 1.0
module tb_tmr_alu_retry_ctrl;
  import tmr_alu_pkg::*;

  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 16;

  typedef struct {
    resp_t r;
    int    lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tmr_alu_retry_ctrl_if #(.CNT_W(CNT_W)) bus ();

  tmr_alu_retry_ctrl #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_corr, exp_fatal;
  logic [31:0] last_a, last_b;
  logic f_inv, f_err_r, f_err_ne, f_err_lt;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Replica array and majority voters, with fault-flag injection on top.
  logic [31:0] r1, r2, r3;
  logic n1, n2, n3, l1, l2, l3;
  always_comb begin
    r1 = alu_fn(bus.alu_opcode, bus.alu_shamt, bus.alu_inA1, bus.alu_inB1);
    r2 = alu_fn(bus.alu_opcode, bus.alu_shamt, bus.alu_inA2, bus.alu_inB2);
    r3 = alu_fn(bus.alu_opcode, bus.alu_shamt, bus.alu_inA3, bus.alu_inB3);
    n1 = (bus.alu_inA1 != bus.alu_inB1);
    n2 = (bus.alu_inA2 != bus.alu_inB2);
    n3 = (bus.alu_inA3 != bus.alu_inB3);
    l1 = ($signed(bus.alu_inA1) < $signed(bus.alu_inB1));
    l2 = ($signed(bus.alu_inA2) < $signed(bus.alu_inB2));
    l3 = ($signed(bus.alu_inA3) < $signed(bus.alu_inB3));
    bus.v_result     = (r1 & r2) | (r1 & r3) | (r2 & r3);
    bus.v_err_result = ((r1 != r2) || (r1 != r3)) | f_err_r;
    bus.v_inv_result = ((r1 != r2) && (r1 != r3) && (r2 != r3)) | f_inv;
    bus.v_isNotEqual = (n1 & n2) | (n1 & n3) | (n2 & n3);
    bus.v_err_ne     = ((n1 != n2) || (n1 != n3)) | f_err_ne;
    bus.v_inv_ne     = 1'b0;
    bus.v_isLessThan = (l1 & l2) | (l1 & l3) | (l2 & l3);
    bus.v_err_lt     = ((l1 != l2) || (l1 != l3)) | f_err_lt;
    bus.v_inv_lt     = 1'b0;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(output resp_t obs);
    obs.result    = bus.resp_result;
    obs.ne        = bus.resp_isNotEqual;
    obs.lt        = bus.resp_isLessThan;
    obs.corrected = bus.resp_corrected;
    obs.fatal     = bus.resp_fatal;
    obs.illegal   = bus.resp_illegal;
    obs.retries   = bus.resp_retries;
  endtask

  // Pushes the expected response, issues the request, and injects invalidOutput on the
  // first n_bad execution attempts (attempt j is voted at the (2j+1)-th edge after accept).
  task automatic run_req(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b, input int n_bad, output resp_t obs, output int lat);
    exp_t e;
    int   k;
    int   w;
    int   ret;
    bit   fat;
    logic err;
    e.r = '0;
    if (op > OP_MAX) begin
      e.r.illegal = 1'b1;
      e.lat       = 1;
    end else begin
      fat = (n_bad > MAX_RETRY);
      ret = fat ? MAX_RETRY : n_bad;
      err = f_err_r | ((op == 5'd1) & (f_err_ne | f_err_lt));
      e.r.result    = alu_fn(op, sh, a, b);
      e.r.retries   = 3'(ret);
      e.r.fatal     = fat;
      e.r.corrected = !fat && err;
      if (!fat && op == 5'd1) begin
        e.r.ne = (a != b);
        e.r.lt = ($signed(a) < $signed(b));
      end
      if (e.r.corrected && exp_corr != '1) exp_corr = exp_corr + 1'b1;
      if (fat && exp_fatal != '1) exp_fatal = exp_fatal + 1'b1;
      e.lat  = 2 + 2 * ret;
      last_a = a;
      last_b = b;
    end
    sb.push_back(e);
    bus.req_opcode = op;
    bus.req_shamt  = sh;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_valid  = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      step();
      w++;
    end
    step();
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.resp_valid && k < 40) begin
      f_inv = ((k + 1) < 2 * n_bad);
      step();
      k++;
    end
    f_inv = 1'b0;
    lat   = bus.resp_valid ? k + 1 : -1;
    sample(obs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    total++; if ({bus.resp_result, bus.resp_corrected, bus.resp_fatal, bus.resp_illegal, bus.resp_retries} !== '0) begin
      bad++; $display("FAIL reset_resp: got %h/%b%b%b/%0d want 0", bus.resp_result, bus.resp_corrected, bus.resp_fatal, bus.resp_illegal, bus.resp_retries);
    end
    total++; if ({bus.alu_inA1, bus.alu_inB3, bus.alu_opcode, bus.alu_shamt} !== '0) begin
      bad++; $display("FAIL reset_alu: got A1=%h B3=%h op=%0d want 0", bus.alu_inA1, bus.alu_inB3, bus.alu_opcode);
    end
    total++; if ({bus.corrected_count, bus.fatal_count} !== '0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.corrected_count, bus.fatal_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clean_add();
    resp_t obs;
    int    lat;
    exp_t  e;
    run_req(5'd0, 5'd0, 32'd5, 32'd7, 0, obs, lat);
    e = sb.pop_front();
    total++; if (obs !== e.r) begin bad++; $display("FAIL add_resp: got %h want %h", obs, e.r); end
    total++; if (obs.result !== 32'd12) begin bad++; $display("FAIL add_result: got %0d want 12", obs.result); end
    total++; if (lat !== e.lat) begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, e.lat); end
    total++; if ({bus.alu_inA1, bus.alu_inA2, bus.alu_inA3, bus.alu_inB1, bus.alu_inB2, bus.alu_inB3} !== {{3{32'd5}}, {3{32'd7}}}) begin
      bad++; $display("FAIL add_fanout: got A=%h,%h,%h B=%h,%h,%h want 5/7", bus.alu_inA1, bus.alu_inA2, bus.alu_inA3, bus.alu_inB1, bus.alu_inB2, bus.alu_inB3);
    end
    step();
    total++; if ({bus.resp_valid, bus.req_ready, bus.resp_result} !== {1'b0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL add_release: got valid=%b ready=%b result=%h want 0/1/0", bus.resp_valid, bus.req_ready, bus.resp_result);
    end
  endtask

  task automatic test_back_to_back();
    resp_t obs;
    int    lat;
    exp_t  e;
    logic [31:0] a, b;
    for (int op = 0; op <= 5; op++) begin
      a = $urandom;
      b = (op == 1) ? a ^ 32'h8000_0001 : $urandom;
      run_req(5'(op), 5'($urandom_range(0, 31)), a, b, 0, obs, lat);
      e = sb.pop_front();
      total++; if (obs !== e.r) begin bad++; $display("FAIL op%0d_resp: got %h want %h", op, obs, e.r); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL op%0d_latency: got %0d want %0d", op, lat, e.lat); end
    end
    step();
  endtask

  task automatic test_corrected();
    resp_t obs;
    int    lat;
    exp_t  e;
    f_err_ne = 1'b1;
    run_req(5'd1, 5'd0, 32'd10, 32'd3, 0, obs, lat);
    e = sb.pop_front();
    total++; if (obs !== e.r) begin bad++; $display("FAIL corr_sub_resp: got %h want %h", obs, e.r); end
    total++; if ({obs.corrected, obs.ne} !== 2'b11) begin bad++; $display("FAIL corr_sub_flags: got %b want 11", {obs.corrected, obs.ne}); end
    step();
    total++; if (bus.corrected_count !== exp_corr) begin bad++; $display("FAIL corr_count_sub: got %0d want %0d", bus.corrected_count, exp_corr); end
    run_req(5'd0, 5'd0, 32'd10, 32'd3, 0, obs, lat);
    e = sb.pop_front();
    total++; if (obs !== e.r) begin bad++; $display("FAIL corr_add_ne_ignored: got %h want %h", obs, e.r); end
    f_err_ne = 1'b0;
    f_err_r  = 1'b1;
    step();
    run_req(5'd2, 5'd0, 32'hF0F0, 32'hFF00, 0, obs, lat);
    e = sb.pop_front();
    total++; if (obs !== e.r) begin bad++; $display("FAIL corr_and_resp: got %h want %h", obs, e.r); end
    f_err_r = 1'b0;
    step();
    total++; if (bus.corrected_count !== exp_corr) begin bad++; $display("FAIL corr_count: got %0d want %0d", bus.corrected_count, exp_corr); end
  endtask

  task automatic test_retry();
    resp_t obs;
    int    lat;
    exp_t  e;
    int    nb[3] = '{1, 2, 5};
    for (int i = 0; i < 3; i++) begin
      run_req(5'd0, 5'd0, 32'd100 + 32'(i), 32'd23, nb[i], obs, lat);
      e = sb.pop_front();
      total++; if (obs !== e.r) begin bad++; $display("FAIL retry%0d_resp: got %h want %h", nb[i], obs, e.r); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL retry%0d_latency: got %0d want %0d", nb[i], lat, e.lat); end
      step();
    end
    total++; if ({bus.fatal_count, bus.corrected_count} !== {exp_fatal, exp_corr}) begin
      bad++; $display("FAIL retry_counters: got fatal=%0d corr=%0d want %0d/%0d", bus.fatal_count, bus.corrected_count, exp_fatal, exp_corr);
    end
  endtask

  task automatic test_illegal();
    resp_t obs;
    int    lat;
    exp_t  e;
    logic [4:0] ops[2] = '{5'd9, 5'd6};
    for (int i = 0; i < 2; i++) begin
      run_req(ops[i], 5'd3, 32'hDEAD_BEEF, 32'h1234_5678, 0, obs, lat);
      e = sb.pop_front();
      total++; if (obs !== e.r) begin bad++; $display("FAIL illegal%0d_resp: got %h want %h", ops[i], obs, e.r); end
      total++; if (lat !== e.lat) begin bad++; $display("FAIL illegal%0d_latency: got %0d want %0d", ops[i], lat, e.lat); end
      total++; if ({bus.alu_inA1, bus.alu_inB2} !== {last_a, last_b}) begin
        bad++; $display("FAIL illegal%0d_alu_hold: got %h/%h want %h/%h", ops[i], bus.alu_inA1, bus.alu_inB2, last_a, last_b);
      end
      step();
    end
    total++; if ({bus.fatal_count, bus.corrected_count} !== {exp_fatal, exp_corr}) begin
      bad++; $display("FAIL illegal_counters: got %0d/%0d want %0d/%0d", bus.fatal_count, bus.corrected_count, exp_fatal, exp_corr);
    end
  endtask

  task automatic test_backpressure_reset();
    resp_t obs;
    resp_t held;
    int    lat;
    exp_t  e;
    bus.resp_ready = 1'b0;
    run_req(5'd3, 5'd0, 32'h0F00_0001, 32'h00F0_0010, 0, held, lat);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      step();
      sample(obs);
      total++; if ({bus.resp_valid, bus.req_ready} !== 2'b10 || obs !== e.r) begin
        bad++; $display("FAIL bp_hold%0d: got valid=%b ready=%b resp=%h want 1/0/%h", c, bus.resp_valid, bus.req_ready, obs, e.r);
      end
    end
    bus.resp_ready = 1'b1;
    step();
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", bus.resp_valid); end
    bus.req_opcode = 5'd1;
    bus.req_a      = 32'd77;
    bus.req_b      = 32'd1;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    step();
    reset     = 1'b0;
    exp_corr  = '0;
    exp_fatal = '0;
    total++; if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      bad++; $display("FAIL rst_exec_state: got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid);
    end
    total++; if ({bus.corrected_count, bus.fatal_count, bus.alu_inA1} !== '0) begin
      bad++; $display("FAIL rst_exec_clear: got corr=%0d fatal=%0d A1=%h want 0", bus.corrected_count, bus.fatal_count, bus.alu_inA1);
    end
    step();
    run_req(5'd1, 5'd0, 32'hFFFF_FFFE, 32'd2, 0, obs, lat);
    e = sb.pop_front();
    total++; if (obs !== e.r || lat !== e.lat) begin
      bad++; $display("FAIL rst_recover: got %h lat=%0d want %h lat=%0d", obs, lat, e.r, e.lat);
    end
    step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = '0;
    bus.req_shamt  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    f_inv          = 1'b0;
    f_err_r        = 1'b0;
    f_err_ne       = 1'b0;
    f_err_lt       = 1'b0;
    exp_corr       = '0;
    exp_fatal      = '0;
    last_a         = '0;
    last_b         = '0;
    test_reset();
    test_clean_add();
    test_back_to_back();
    test_corrected();
    test_retry();
    test_illegal();
    test_backpressure_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
